// File: rtl/logic_unit_arbiter.sv
// Four requesters share one WIDTH-bit NOT/AND/OR/XOR unit through a round-robin arbiter.
// The arbiter accepts one operation every three cycles and returns the result tagged with the requester ID.
module logic_unit_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [3:0]         i_req,
  input  logic [7:0]         i_req_op,
  input  logic [4*WIDTH-1:0] i_req_a,
  input  logic [4*WIDTH-1:0] i_req_b,
  output logic [3:0]         o_grant,
  output logic               o_rsp_valid,
  output logic [1:0]         o_rsp_id,
  output logic [WIDTH-1:0]   o_rsp_data,
  output logic               o_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  state_t           r_state;
  logic [1:0]       r_last;
  logic [1:0]       r_id;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;

  logic [1:0]       w_winner;
  logic [1:0]       w_cand;
  logic             w_found;
  logic [WIDTH-1:0] w_result;

  // Search last+1 .. last+4 (wrapping); the offset of 4 lands back on last itself.
  always_comb begin
    w_winner = r_last;
    w_cand   = r_last;
    w_found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      w_cand = r_last + 2'(k);
      if (!w_found && i_req[w_cand]) begin
        w_winner = w_cand;
        w_found  = 1'b1;
      end
    end
  end

  always_comb begin
    w_result = '0;
    case (r_op)
      2'b00:   w_result = ~r_a;
      2'b01:   w_result = r_a & r_b;
      2'b10:   w_result = r_a | r_b;
      default: w_result = r_a ^ r_b;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_last      <= 2'd3;
      r_id        <= '0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      o_grant     <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_id    <= '0;
      o_rsp_data  <= '0;
      o_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          o_rsp_valid <= 1'b0;
          if (|i_req) begin
            r_id    <= w_winner;
            r_op    <= i_req_op[2*w_winner +: 2];
            r_a     <= i_req_a[WIDTH*w_winner +: WIDTH];
            r_b     <= i_req_b[WIDTH*w_winner +: WIDTH];
            o_grant <= 4'b0001 << w_winner;
            o_busy  <= 1'b1;
            r_state <= S_EXEC;
          end else begin
            o_grant <= '0;
            o_busy  <= 1'b0;
          end
        end
        S_EXEC: begin
          o_grant     <= '0;
          o_rsp_valid <= 1'b1;
          o_rsp_id    <= r_id;
          o_rsp_data  <= w_result;
          r_last      <= r_id;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          o_rsp_valid <= 1'b0;
          o_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          o_grant     <= '0;
          o_rsp_valid <= 1'b0;
          o_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: a vector table plus directed multi-cycle sequences,
// with every expected response queued at grant time and matched against each rsp_valid pulse.
module tb_logic_unit_arbiter;

  localparam int WIDTH = 8;

  logic               clk;
  logic               rst_n;
  logic [3:0]         req;
  logic [7:0]         reqOp;
  logic [4*WIDTH-1:0] reqA;
  logic [4*WIDTH-1:0] reqB;
  logic [3:0]         grant;
  logic               rspValid;
  logic [1:0]         rspId;
  logic [WIDTH-1:0]   rspData;
  logic               busy;

  int nCompared   = 0;
  int nMismatched = 0;

  typedef struct {
    logic [1:0]       id;
    logic [WIDTH-1:0] data;
  } exp_t;
  exp_t sbQ[$];

  typedef struct {
    int               id;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] expData;
  } vec_t;

  logic_unit_arbiter #(.WIDTH(WIDTH)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req       (req),
    .i_req_op    (reqOp),
    .i_req_a     (reqA),
    .i_req_b     (reqB),
    .o_grant     (grant),
    .o_rsp_valid (rspValid),
    .o_rsp_id    (rspId),
    .o_rsp_data  (rspData),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=still running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    nCompared++;
    if (actual !== required) begin
      nMismatched++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, required);
    end
  endtask

  function automatic logic [WIDTH-1:0] calcExpected(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
    case (op)
      2'b00:   return ~a;
      2'b01:   return a & b;
      2'b10:   return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // Every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rspValid === 1'b1) begin
      if (sbQ.size() == 0) begin
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL unexpected_rsp: actual=id %0d data %h required=no response", rspId, rspData);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput("rsp_id", 32'(rspId), 32'(e.id));
        checkOutput("rsp_data", 32'(rspData), 32'(e.data));
      end
    end
  end

  task automatic setReq(input int id, input logic [1:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b);
    reqOp[2*id +: 2]         = op;
    reqA[WIDTH*id +: WIDTH]  = a;
    reqB[WIDTH*id +: WIDTH]  = b;
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic waitGrant(output logic [3:0] g, output int cycles, output bit found);
    found  = 1'b0;
    cycles = 0;
    g      = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      cycles++;
      if (grant !== 4'b0000) begin
        g     = grant;
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL grant_timeout: actual=no grant required=grant within 12 cycles");
    end
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 12 && sbQ.size() != 0; i++) @(negedge clk);
    if (sbQ.size() != 0) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL rsp_timeout: actual=%0d pending required=0 pending", sbQ.size());
      sbQ.delete();
    end
  endtask

  task automatic applyStimulus(input int id, input logic [1:0] op, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] expData);
    logic [3:0] g;
    int         cyc;
    bit         found;
    setReq(id, op, a, b);
    req = 4'b0001 << id;
    waitGrant(g, cyc, found);
    if (found) begin
      checkOutput($sformatf("grant_r%0d", id), 32'(g), 32'(4'b0001 << id));
      sbQ.push_back('{id: 2'(id), data: expData});
    end
    req = '0;
    waitDrain();
  endtask

  initial begin
    vec_t       vecs[$];
    logic [3:0] g;
    int         cyc;
    bit         found;
    int         fairIds[5] = '{0, 1, 2, 3, 0};

    rst_n = 1'b0;
    req   = '0;
    reqOp = '0;
    reqA  = '0;
    reqB  = '0;

    vecs.push_back('{id: 2, op: 2'b00, a: 8'hF0, b: 8'h3C, expData: 8'h0F});
    vecs.push_back('{id: 2, op: 2'b01, a: 8'hF0, b: 8'h3C, expData: 8'h30});
    vecs.push_back('{id: 2, op: 2'b10, a: 8'hF0, b: 8'h3C, expData: 8'hFC});
    vecs.push_back('{id: 2, op: 2'b11, a: 8'hF0, b: 8'h3C, expData: 8'hCC});
    vecs.push_back('{id: 1, op: 2'b01, a: 8'hFF, b: 8'h00, expData: 8'h00});
    vecs.push_back('{id: 3, op: 2'b10, a: 8'h00, b: 8'h00, expData: 8'h00});
    vecs.push_back('{id: 0, op: 2'b11, a: 8'hAA, b: 8'h55, expData: 8'hFF});
    vecs.push_back('{id: 3, op: 2'b00, a: 8'hFF, b: 8'hAB, expData: 8'h00});
    vecs.push_back('{id: 1, op: 2'b00, a: 8'h00, b: 8'hFF, expData: 8'hFF});

    repeat (2) @(negedge clk);
    checkOutput("reset_grant", 32'(grant), 32'h0);
    checkOutput("reset_rsp_valid", 32'(rspValid), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_rsp_id", 32'(rspId), 32'h0);
    checkOutput("reset_rsp_data", 32'(rspData), 32'h0);

    // Single NOT with exact cycle-by-cycle latency.
    rst_n = 1'b1;
    setReq(0, 2'b00, 8'h5A, 8'h00);
    req = 4'b0001;
    @(negedge clk);
    checkOutput("lat_grant", 32'(grant), 32'h1);
    checkOutput("lat_busy1", 32'(busy), 32'h1);
    checkOutput("lat_valid1", 32'(rspValid), 32'h0);
    sbQ.push_back('{id: 2'd0, data: 8'hA5});
    req = '0;
    @(negedge clk);
    checkOutput("lat_grant_off", 32'(grant), 32'h0);
    checkOutput("lat_busy2", 32'(busy), 32'h1);
    checkOutput("lat_valid2", 32'(rspValid), 32'h1);
    @(negedge clk);
    checkOutput("lat_busy3", 32'(busy), 32'h0);
    checkOutput("lat_valid3", 32'(rspValid), 32'h0);
    waitDrain();

    foreach (vecs[i]) applyStimulus(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expData);

    // Fairness from a fresh reset: all four requesting continuously.
    resetDut();
    setReq(0, 2'b00, 8'h5A, 8'h00);
    setReq(1, 2'b01, 8'hF0, 8'h3C);
    setReq(2, 2'b10, 8'hF0, 8'h3C);
    setReq(3, 2'b11, 8'hF0, 8'h3C);
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      waitGrant(g, cyc, found);
      if (!found) break;
      checkOutput($sformatf("fair_grant%0d", n), 32'(g), 32'(4'b0001 << fairIds[n]));
      if (n > 0) checkOutput($sformatf("fair_spacing%0d", n), 32'(cyc), 32'd3);
      sbQ.push_back('{id: 2'(fairIds[n]),
                      data: calcExpected(reqOp[2*fairIds[n] +: 2], reqA[WIDTH*fairIds[n] +: WIDTH],
                                         reqB[WIDTH*fairIds[n] +: WIDTH])});
    end
    req = '0;
    waitDrain();

    // Round-robin skip: after serving 1, requesters 3 then 0 win.
    applyStimulus(1, 2'b11, 8'h0F, 8'hFF, 8'hF0);
    setReq(3, 2'b01, 8'hAA, 8'h0F);
    setReq(0, 2'b10, 8'h11, 8'h22);
    req = 4'b1001;
    waitGrant(g, cyc, found);
    checkOutput("skip_grant_r3", 32'(g), 32'h8);
    if (found) sbQ.push_back('{id: 2'd3, data: 8'h0A});
    waitGrant(g, cyc, found);
    checkOutput("skip_grant_r0", 32'(g), 32'h1);
    if (found) sbQ.push_back('{id: 2'd0, data: 8'h33});
    req = '0;
    waitDrain();

    // Operand isolation: operand A changes after acceptance must not leak in.
    setReq(0, 2'b01, 8'h3C, 8'hFF);
    req = 4'b0001;
    waitGrant(g, cyc, found);
    checkOutput("iso_grant", 32'(g), 32'h1);
    if (found) sbQ.push_back('{id: 2'd0, data: 8'h3C});
    req = '0;
    reqA[7:0] = 8'hFF;
    @(negedge clk);
    reqA[7:0] = 8'h81;
    waitDrain();
    @(negedge clk);
    checkOutput("hold_valid_low", 32'(rspValid), 32'h0);
    checkOutput("hold_rsp_data", 32'(rspData), 32'h3C);
    checkOutput("hold_rsp_id", 32'(rspId), 32'h0);

    // Reset during EXEC aborts the operation.
    setReq(0, 2'b00, 8'h12, 8'h00);
    req = 4'b0001;
    waitGrant(g, cyc, found);
    checkOutput("abort_grant", 32'(g), 32'h1);
    #2;
    rst_n = 1'b0;
    req   = '0;
    #1;
    checkOutput("abort_grant_drop", 32'(grant), 32'h0);
    checkOutput("abort_busy_drop", 32'(busy), 32'h0);
    repeat (3) @(negedge clk);
    setReq(2, 2'b01, 8'hF0, 8'h3C);
    req   = 4'b0100;
    rst_n = 1'b1;
    waitGrant(g, cyc, found);
    checkOutput("post_reset_grant", 32'(g), 32'h4);
    if (found) sbQ.push_back('{id: 2'd2, data: 8'h30});
    req = '0;
    waitDrain();
    repeat (3) @(negedge clk);

    checkOutput("sb_empty", 32'(sbQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
